peak_index_logger: RTL and testbench

//  Downstream consumer of the local-maxima stage. Samples its 1-bit per-sample peak flag
//  and its finish strobe, and tags every detected peak with its sample index.

---
 rtl/peak_index_logger.sv | 188 ++++++++++++++++++
 tb/tb_peak_index_logger.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_index_logger.sv
// -----------------------------------------------------------------------------
// peak_index_logger
//
// Purpose
//   Consumes the per-sample peak flag from the local-maxima stage and records
//   the sample index of each peak in a small FIFO. The FIFO is read out over a
//   valid/ready port. The block also keeps a saturating peak count and runs an
//   end-of-stream sequence: collect, then drain, then done.
//
// Parameters
//   IDX_W      width of the sample index counter (wraps modulo 2^IDX_W)
//   DEPTH      FIFO entries; must be a power of two and at least 2
//   CNT_W      width of peak_cnt (saturates at 2^CNT_W-1)
//   IDX_OFFSET pipeline lag of peak_in relative to its sample
//
// Ports
//   clk        in   clock; all logic on the rising edge
//   rst        in   synchronous, active-high reset
//   en         in   sample strobe
//   peak_in    in   local-maximum flag, qualified by en
//   finish_in  in   end-of-stream strobe
//   rd_ready   in   consumer accepts the head entry
//   rd_valid   out  FIFO not empty
//   rd_idx     out  head entry (first-word-fall-through), 0 when empty
//   peak_cnt   out  peaks seen since reset, including dropped ones
//   overflow   out  sticky: at least one push was lost or overwritten
//   done       out  stream finished and FIFO drained
//
// Configuration macro
//   PEAK_DROP_OLDEST_EN  when defined, a push into a full FIFO with no pop
//                        overwrites the oldest entry. When undefined, the new
//                        entry is dropped.
// -----------------------------------------------------------------------------
module peak_index_logger #(
  parameter int IDX_W      = 8,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 8,
  parameter int IDX_OFFSET = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             peak_in,
  input  logic             finish_in,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] peak_cnt,
  output logic             overflow,
  output logic             done
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [IDX_W-1:0] OFS_C = IDX_W'(IDX_OFFSET);

  // Reject DEPTH values that the pointer arithmetic cannot handle.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("peak_index_logger: DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  smp_idx_q, smp_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       occ_q, occ_d;
  logic [IDX_W-1:0]  mem_q [DEPTH];

  logic              sample;
  logic              push_req;
  logic              pop;
  logic              full;
  logic              wr_en;
  logic [IDX_W-1:0]  push_idx;

  // IDLE also samples: the first en=1 cycle is processed as index 0 while the
  // FSM moves into COLLECT.
  assign sample   = en && ((state_q == S_IDLE) || (state_q == S_COLLECT));
  assign push_req = sample && peak_in;
  assign push_idx = smp_idx_q - OFS_C;

  assign rd_valid = (occ_q != '0);
  assign pop      = rd_valid && rd_ready;
  assign full     = (occ_q == DEPTH_C);

  // ---------------------------------------------------------------------------
  // FIFO pointer / occupancy next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (push_req) begin
      if (full && !pop) begin
        ovf_d = 1'b1;
`ifdef PEAK_DROP_OLDEST_EN
        // When full, wr_ptr == rd_ptr. Writing there replaces the oldest
        // entry. Advancing both pointers keeps the newest DEPTH entries.
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
`endif
      end else begin
        // With a simultaneous pop into a full FIFO, the write slot is the one
        // being popped on this edge, so the write is safe.
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (!pop) occ_d = occ_q + 1'b1;
      end
    end else if (pop) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample index and peak counter
  // ---------------------------------------------------------------------------
  always_comb begin
    smp_idx_d = smp_idx_q;
    cnt_d     = cnt_q;
    if (sample) smp_idx_d = smp_idx_q + 1'b1;
    if (push_req && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Stream FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (en)        state_d = S_COLLECT;
      S_COLLECT: if (finish_in) state_d = S_DRAIN;
      // Test the post-edge occupancy so that done rises in the cycle right
      // after the final pop.
      S_DRAIN:   if (occ_d == '0) state_d = S_DONE;
      S_DONE:                   state_d = S_DONE;
      default:                  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      smp_idx_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      smp_idx_q <= smp_idx_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  // The storage array is not reset. Stale contents are never visible because
  // rd_idx is gated by rd_valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= push_idx;
  end

  assign rd_idx   = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign peak_cnt = cnt_q;
  assign overflow = ovf_q;
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_peak_index_logger.sv
// Bench for peak_index_logger. A scoreboard queue holds the expected FIFO
// contents, updated as stimulus is driven. Entries are popped and compared when
// the DUT pops. A second instance with IDX_W=4 covers index wraparound.
module tb_peak_index_logger;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, peak_in = 1'b0, finish_in = 1'b0, rd_ready = 1'b0;
  logic       rd_valid, overflow, done;
  logic [7:0] rd_idx, peak_cnt;
  logic       rd_valid4, overflow4, done4;
  logic [3:0] rd_idx4;
  logic [7:0] peak_cnt4;

  int total = 0;
  int bad   = 0;

  // model state
  logic [7:0] sb[$];
  logic [7:0] exp_cnt = 8'd0;
  logic       exp_ovf = 1'b0;
  logic [7:0] m_idx   = 8'd0;
  int         m_st    = 0;   // 0 idle, 1 collect, 2 drain, 3 done

  always #5 clk = ~clk;

  peak_index_logger #(.IDX_W(8), .DEPTH(DEPTH), .CNT_W(8), .IDX_OFFSET(1)) dut (
    .clk(clk), .rst(rst), .en(en), .peak_in(peak_in), .finish_in(finish_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .peak_cnt(peak_cnt), .overflow(overflow), .done(done)
  );

  peak_index_logger #(.IDX_W(4), .DEPTH(DEPTH), .CNT_W(8), .IDX_OFFSET(1)) dut4 (
    .clk(clk), .rst(rst), .en(en), .peak_in(peak_in), .finish_in(finish_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid4), .rd_idx(rd_idx4),
    .peak_cnt(peak_cnt4), .overflow(overflow4), .done(done4)
  );

  // One cycle: drive inputs at negedge, check current outputs, advance model.
  task automatic step(input logic e, input logic p, input logic f, input logic r);
    logic       pop_m, act;
    logic [7:0] pidx;
    @(negedge clk);
    en = e; peak_in = p; finish_in = f; rd_ready = r;
    total++;
    if (rd_valid !== (sb.size() != 0)) begin
      bad++; $display("FAIL rd_valid: got %b want %b", rd_valid, (sb.size() != 0));
    end
    total++;
    if (peak_cnt !== exp_cnt) begin
      bad++; $display("FAIL peak_cnt: got %0d want %0d", peak_cnt, exp_cnt);
    end
    total++;
    if (overflow !== exp_ovf) begin
      bad++; $display("FAIL overflow: got %b want %b", overflow, exp_ovf);
    end
    total++;
    if (done !== (m_st == 3)) begin
      bad++; $display("FAIL done: got %b want %b", done, (m_st == 3));
    end
    pop_m = (sb.size() != 0) && r;
    if (pop_m) begin
      total++;
      if (rd_idx !== sb[0]) begin
        bad++; $display("FAIL rd_idx: got %0d want %0d", rd_idx, sb[0]);
      end
      void'(sb.pop_front());
    end
    act = ((m_st == 0) || (m_st == 1)) && e;
    if (act && p) begin
      pidx = m_idx - 8'd1;
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      if (sb.size() == DEPTH) begin
        exp_ovf = 1'b1;
`ifdef PEAK_DROP_OLDEST_EN
        void'(sb.pop_front());
        sb.push_back(pidx);
`endif
      end else begin
        sb.push_back(pidx);
      end
    end
    if (act) m_idx = m_idx + 8'd1;
    case (m_st)
      0: if (e) m_st = 1;
      1: if (f) m_st = 2;
      2: if (sb.size() == 0) m_st = 3;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; peak_in = 1'b0; finish_in = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete(); exp_cnt = 8'd0; exp_ovf = 1'b0; m_idx = 8'd0; m_st = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    total++;
    if ({rd_valid, rd_idx, peak_cnt, overflow, done} !== 19'd0) begin
      bad++;
      $display("FAIL %s: got v=%b idx=%0d cnt=%0d ovf=%b done=%b want all 0",
               tag, rd_valid, rd_idx, peak_cnt, overflow, done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk_reset_vals("reset_state");
    total++;
    if ({rd_valid4, rd_idx4, overflow4, done4} !== 7'd0) begin
      bad++; $display("FAIL reset_state4: got v=%b idx=%0d want 0", rd_valid4, rd_idx4);
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int k = 0; k < 12; k++) step(1'b1, (k == 2) || (k == 4) || (k == 8), 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (peak_cnt !== 8'd3 || overflow !== 1'b0) begin
      bad++; $display("FAIL basic_end: got cnt=%0d ovf=%b want cnt=3 ovf=0", peak_cnt, overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k <= 10; k++) step(1'b1, k >= 1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (peak_cnt !== 8'd10 || overflow !== 1'b1) begin
      bad++; $display("FAIL overflow_end: got cnt=%0d ovf=%b want cnt=10 ovf=1", peak_cnt, overflow);
    end
    total++;
`ifdef PEAK_DROP_OLDEST_EN
    if (rd_idx !== 8'd2) begin bad++; $display("FAIL overflow_head: got %0d want 2", rd_idx); end
`else
    if (rd_idx !== 8'd0) begin bad++; $display("FAIL overflow_head: got %0d want 0", rd_idx); end
`endif
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int k = 0; k <= 8; k++) step(1'b1, k >= 1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);   // full: push and pop together
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (overflow !== 1'b0 || rd_valid !== 1'b1 || sb.size() != DEPTH) begin
      bad++; $display("FAIL full_push_pop: got ovf=%b v=%b want ovf=0 v=1", overflow, rd_valid);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_finish();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);   // peak in the finish cycle is still logged
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (done !== 1'b0 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL finish_drain: got done=%b v=%b want done=0 v=1", done, rd_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL finish_done: got %b want 1", done); end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (peak_cnt !== 8'd2 || done !== 1'b1 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL finish_hold: got cnt=%0d done=%b v=%b want 2 1 0", peak_cnt, done, rd_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k <= 17; k++) step(1'b1, (k == 16) || (k == 17), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (rd_valid4 !== 1'b1 || rd_idx4 !== 4'd15) begin
      bad++; $display("FAIL wrap_head0: got v=%b idx=%0d want 1 15", rd_valid4, rd_idx4);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (rd_valid4 !== 1'b1 || rd_idx4 !== 4'd0) begin
      bad++; $display("FAIL wrap_head1: got v=%b idx=%0d want 1 0", rd_valid4, rd_idx4);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 300; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (peak_cnt !== 8'hFF) begin bad++; $display("FAIL saturate: got %0d want 255", peak_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (peak_cnt !== 8'd5 || sb.size() != 3 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL mid_setup: got cnt=%0d v=%b want 5 1", peak_cnt, rd_valid);
    end
    do_reset();
    chk_reset_vals("reset_mid");
    step(1'b1, 1'b1, 1'b0, 1'b0);   // restarts at idx 0 -> logs 255
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (rd_idx !== 8'd255) begin bad++; $display("FAIL mid_restart: got %0d want 255", rd_idx); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, 1'b0, $urandom_range(0, 1) == 1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL random_done: got %b want 1", done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_finish();
    test_wrap();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
